psum_row_collect: RTL and testbench

- Downstream stage of the 3x3 PE array in the conv engine.
- Each beat takes the three row partial sums (PE rows 1..3) for one output pixel and adds them with saturation.
- Stores a full DO_W x DO_H (5x5) output frame in raster order, then drains it serially to DRAM over a valid/ready write port.
- Replaces the combinational row adder with a buffered, handshaked collector.

---
 rtl/psum_row_collect.sv | 161 ++++++++++++++++
 tb/tb_psum_row_collect.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_row_collect.sv
// Row partial-sum collector: saturating 3-way add per beat, buffers a DO_W x DO_H frame,
// then drains it in raster order. Define PSUM_ROW_COLLECT_RELU_EN to clamp negatives to 0.
module psum_row_collect #(
  parameter int unsigned INWIDTH = 16,
  parameter int unsigned IN_FRAC = 12,
  parameter int unsigned DO_W    = 5,
  parameter int unsigned DO_H    = 5,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PSUM_VLD,
  output logic               PSUM_RDY,
  input  logic [INWIDTH-1:0] PSUM_R1,
  input  logic [INWIDTH-1:0] PSUM_R2,
  input  logic [INWIDTH-1:0] PSUM_R3,
  output logic               DO_VLD,
  input  logic               DO_RDY,
  output logic [INWIDTH-1:0] DO_DATA,
  output logic [ADDR_W-1:0]  DO_ADDR,
  output logic               FRAME_DONE,
  output logic               BUSY
);

  localparam int unsigned N     = DO_W * DO_H;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned SumW  = INWIDTH + 2;
  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [CntW-1:0]        NCnt     = CntW'(N);
  localparam logic [ADDR_W-1:0]      LastAddr = ADDR_W'(N - 1);
  localparam logic signed [SumW-1:0] SatMax   = {3'b000, {(INWIDTH - 1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin   = {3'b111, {(INWIDTH - 1){1'b0}}};

  // Q-format is carried through unchanged; only sanity-check the configuration.
  if (IN_FRAC >= INWIDTH || Depth < N) begin : gen_bad_cfg
    $error("psum_row_collect: invalid IN_FRAC or ADDR_W too small for DO_W*DO_H");
  end

  typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                s1_vld_q, s1_vld_d;
  logic [INWIDTH-1:0]  s1_sum_q, s1_sum_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;
  logic [INWIDTH-1:0]  mem_q [Depth];

  logic signed [SumW-1:0] r1_ext, r2_ext, r3_ext, sum_full;
  logic [INWIDTH-1:0]     pix;
  logic                   accept, do_vld, do_hs;

  always_comb begin
    r1_ext   = {{2{PSUM_R1[INWIDTH-1]}}, PSUM_R1};
    r2_ext   = {{2{PSUM_R2[INWIDTH-1]}}, PSUM_R2};
    r3_ext   = {{2{PSUM_R3[INWIDTH-1]}}, PSUM_R3};
    sum_full = r1_ext + r2_ext + r3_ext;
    if (sum_full > SatMax) begin
      pix = SatMax[INWIDTH-1:0];
    end else if (sum_full < SatMin) begin
      pix = SatMin[INWIDTH-1:0];
    end else begin
      pix = sum_full[INWIDTH-1:0];
    end
`ifdef PSUM_ROW_COLLECT_RELU_EN
    if (pix[INWIDTH-1]) begin
      pix = '0;
    end
`endif
  end

  assign accept = PSUM_VLD & rdy_q;
  assign do_vld = (state_q == StDrain);
  assign do_hs  = do_vld & DO_RDY;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;
    s1_vld_d  = accept;
    s1_sum_d  = accept ? pix : s1_sum_q;

    if (accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (s1_vld_q) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (s1_vld_q && wr_ptr_q == LastAddr) begin
          state_d  = StDrain;
          wr_ptr_d = '0;
        end
      end
      StDrain: begin
        if (do_hs) begin
          if (rd_ptr_q == LastAddr) begin
            state_d   = StIdle;
            rd_ptr_d  = '0;
            acc_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready is registered from the next state so it never glitches and is low in reset.
    rdy_d = (state_d == StIdle) || ((state_d == StFill) && (acc_cnt_d < NCnt));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      acc_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_sum_q  <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_sum_q  <= s1_sum_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (s1_vld_q) begin
      mem_q[wr_ptr_q] <= s1_sum_q;
    end
  end

  assign PSUM_RDY   = rdy_q;
  assign DO_VLD     = do_vld;
  assign DO_ADDR    = do_vld ? rd_ptr_q : '0;
  assign DO_DATA    = do_vld ? mem_q[rd_ptr_q] : '0;
  assign FRAME_DONE = done_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_psum_row_collect.sv
// Self-checking bench for psum_row_collect: directed frame sequence with random data,
// checked against a plain-arithmetic saturating-sum model.
module tb_psum_row_collect;

  localparam int N = 25;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PSUM_VLD;
  logic        PSUM_RDY;
  logic [15:0] PSUM_R1, PSUM_R2, PSUM_R3;
  logic        DO_VLD;
  logic        DO_RDY;
  logic [15:0] DO_DATA;
  logic [4:0]  DO_ADDR;
  logic        FRAME_DONE;
  logic        BUSY;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [15:0] f1 [N];
  logic [15:0] f2 [N];
  logic [15:0] f3 [N];
  logic [15:0] expq [N];

  psum_row_collect dut (
    .CLK       (CLK),
    .RST       (RST),
    .PSUM_VLD  (PSUM_VLD),
    .PSUM_RDY  (PSUM_RDY),
    .PSUM_R1   (PSUM_R1),
    .PSUM_R2   (PSUM_R2),
    .PSUM_R3   (PSUM_R3),
    .DO_VLD    (DO_VLD),
    .DO_RDY    (DO_RDY),
    .DO_DATA   (DO_DATA),
    .DO_ADDR   (DO_ADDR),
    .FRAME_DONE(FRAME_DONE),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'($signed(c));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef PSUM_ROW_COLLECT_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  function automatic logic [15:0] rnd_psum();
    case ($urandom_range(0, 5))
      0:       return 16'h7000;
      1:       return 16'h9000;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic fill_exp();
    for (int i = 0; i < N; i++) expq[i] = ref_pix(f1[i], f2[i], f3[i]);
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      f1[i] = rnd_psum();
      f2[i] = rnd_psum();
      f3[i] = rnd_psum();
    end
    fill_exp();
  endtask

  // Called #1 after a rising edge; returns #1 after the edge starting cycle t+2.
  task automatic send_frame(input bit gaps, input bit expect_done);
    int k = 0;
    int cyc = 0;
    bit first = 1'b1;
    while (k < N && cyc < 1000) begin
      PSUM_VLD = (gaps && !first) ? ($urandom_range(0, 2) != 0) : 1'b1;
      PSUM_R1  = f1[k];
      PSUM_R2  = f2[k];
      PSUM_R3  = f3[k];
      @(negedge CLK);
      if (first && expect_done) begin
        chk("done_cycle_pulse", {31'd0, FRAME_DONE}, 32'd1);
        chk("done_cycle_rdy", {31'd0, PSUM_RDY}, 32'd1);
      end
      first = 1'b0;
      if (PSUM_VLD && PSUM_RDY) k++;
      @(posedge CLK);
      #1;
      cyc++;
    end
    PSUM_VLD = 1'b0;
    chk("fill_beats", k, N);
    @(negedge CLK);
    chk("lat_t1_vld", {31'd0, DO_VLD}, 32'd0);
    chk("full_rdy", {31'd0, PSUM_RDY}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  // rdy_mode: 0 always ready, 1 toggle every cycle, 2 random.
  task automatic drain(input int rdy_mode, input bit poke_in, input int stop_after);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_after && cyc < 1000) begin
      case (rdy_mode)
        0:       DO_RDY = 1'b1;
        1:       DO_RDY = (cyc % 2) == 1;
        default: DO_RDY = ($urandom_range(0, 1) == 1);
      endcase
      if (poke_in) begin
        PSUM_VLD = 1'b1;
        PSUM_R1  = 16'($urandom);
        PSUM_R2  = 16'($urandom);
        PSUM_R3  = 16'($urandom);
      end
      @(negedge CLK);
      chk("drain_vld", {31'd0, DO_VLD}, 32'd1);
      chk("drain_addr", {27'd0, DO_ADDR}, idx);
      chk("drain_data", {16'd0, DO_DATA}, {16'd0, expq[idx]});
      chk("drain_busy", {31'd0, BUSY}, 32'd1);
      if (poke_in) chk("drain_in_rdy", {31'd0, PSUM_RDY}, 32'd0);
      if (DO_VLD && DO_RDY) idx++;
      @(posedge CLK);
      #1;
      cyc++;
    end
    PSUM_VLD = 1'b0;
    DO_RDY   = 1'b1;
    chk("drain_words", idx, stop_after);
  endtask

  task automatic finish_done();
    @(negedge CLK);
    chk("done_pulse", {31'd0, FRAME_DONE}, 32'd1);
    chk("done_vld", {31'd0, DO_VLD}, 32'd0);
    chk("done_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("done_one_cycle", {31'd0, FRAME_DONE}, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_rdy"}, {31'd0, PSUM_RDY}, 32'd0);
    chk({tag, "_vld"}, {31'd0, DO_VLD}, 32'd0);
    chk({tag, "_data"}, {16'd0, DO_DATA}, 32'd0);
    chk({tag, "_addr"}, {27'd0, DO_ADDR}, 32'd0);
    chk({tag, "_done"}, {31'd0, FRAME_DONE}, 32'd0);
    chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    RST      = 1'b0;
    PSUM_VLD = 1'b0;
    DO_RDY   = 1'b1;
    PSUM_R1  = '0;
    PSUM_R2  = '0;
    PSUM_R3  = '0;
    #12;
    check_outputs_zero("reset");
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("idle_rdy", {31'd0, PSUM_RDY}, 32'd1);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK);
    #1;

    // Frame A: constant triple, no backpressure.
    for (int i = 0; i < N; i++) begin
      f1[i] = 16'h1000;
      f2[i] = 16'h0800;
      f3[i] = 16'h0400;
    end
    fill_exp();
    chk("model_1c00", {16'd0, expq[0]}, 32'h1C00);
    send_frame(1'b0, 1'b0);
    drain(0, 1'b0, N);
    finish_done();

    // Frame B: saturation corners, toggling DO_RDY, input poked during drain.
    load_random();
    f1[0] = 16'h7000; f2[0] = 16'h7000; f3[0] = 16'h7000;
    f1[1] = 16'h9000; f2[1] = 16'h9000; f3[1] = 16'h9000;
    fill_exp();
    send_frame(1'b0, 1'b0);
    drain(1, 1'b1, N);
    finish_done();

    // Frame C: pixel k = k+k+k with random input gaps.
    for (int i = 0; i < N; i++) begin
      f1[i] = 16'(i);
      f2[i] = 16'(i);
      f3[i] = 16'(i);
    end
    fill_exp();
    send_frame(1'b1, 1'b0);
    drain(2, 1'b0, N);
    finish_done();

    // Frame D: reset after 10 drained words.
    load_random();
    send_frame(1'b0, 1'b0);
    drain(0, 1'b0, 10);
    #2;
    RST = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    chk("post_reset_done_cnt", done_cnt, 3);

    // Frames E and F back-to-back, F's first beat offered in E's FRAME_DONE cycle.
    d0 = done_cnt;
    load_random();
    send_frame(1'b1, 1'b0);
    drain(2, 1'b0, N);
    load_random();
    send_frame(1'b0, 1'b1);
    drain(0, 1'b0, N);
    finish_done();
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("total_done_pulses", done_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
